// File: rtl/launch_pkg.sv
// rtl/launch_pkg.sv - shared FSM states, button indices and arrow step constants
//   Contents: launch_state_e (IDLE/HOLD/LOCKED), BTN_* button indices
//   (the index order is also the press priority, lowest index wins),
//   AX_*/AY_* arrow pixel offsets per Ang/Vel code step.
package launch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        LOCKED = 2'd2
    } launch_state_e;

    localparam logic [1:0] BTN_ANGUP = 2'd0;
    localparam logic [1:0] BTN_ANGDN = 2'd1;
    localparam logic [1:0] BTN_PWRUP = 2'd2;
    localparam logic [1:0] BTN_PWRDN = 2'd3;

    localparam int AX_ANG = 1;
    localparam int AY_ANG = 4;
    localparam int AX_VEL = 4;
    localparam int AY_VEL = 10;

endpackage

// File: rtl/arrow_hit.sv
// rtl/arrow_hit.sv - registered pixel-inside-arrow compare
//   Ports: clk, rst (async, active-low), i_arrow_x/i_arrow_y (11-bit arrow
//   corner), i_x/i_y (current pixel), o_hit (registered, 1 clk latency).
//   Both bounds are strict, so the inside spans SZ-1 pixels per axis.
module arrow_hit #(
    parameter int SZ = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] i_arrow_x,
    input  logic [10:0] i_arrow_y,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    output logic        o_hit
);

    logic [10:0] w_x;
    logic [10:0] w_y;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_hit;
    logic        r_hit;

    assign w_x     = {1'b0, i_x};
    assign w_y     = {1'b0, i_y};
    assign w_x_end = i_arrow_x + 11'(SZ);
    assign w_y_end = i_arrow_y + 11'(SZ);

    assign w_hit = (i_arrow_x < w_x) && (w_x < w_x_end) &&
                   (i_arrow_y < w_y) && (w_y < w_y_end);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_hit;
        end
    end

    assign o_hit = r_hit;

endmodule

// File: rtl/launch_param_ctrl.sv
// rtl/launch_param_ctrl.sv - launch angle/velocity selector with arrow cursor
//   Ports: clk, rst (async, active-low), tick (update enable),
//   btn_n[3:0] {powerdown, powerup, angledown, angleup} active-low,
//   fire_n (active-low launch), lock (ball in flight), xCount/yCount (pixel),
//   arrow (registered hit), Ang/Vel (current codes), launch (1-clk pulse).
//   Optional: LAUNCH_AUTOREPEAT_EN adds held-button auto-repeat in HOLD.
module launch_param_ctrl #(
    parameter int ANG_W      = 5,
    parameter int ANG_MAX    = 16,
    parameter int VEL_W      = 3,
    parameter int VEL_MAX    = 5,
    parameter int ORIGIN_X   = 31,
    parameter int ORIGIN_Y   = 443,
    parameter int ARROW_SZ   = 10,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [3:0]       btn_n,
    input  logic             fire_n,
    input  logic             lock,
    input  logic [9:0]       xCount,
    input  logic [9:0]       yCount,
    output logic             arrow,
    output logic [ANG_W-1:0] Ang,
    output logic [VEL_W-1:0] Vel,
    output logic             launch
);

    import launch_pkg::*;

    if (ANG_MAX >= (1 << ANG_W)) begin : g_bad_ang_max
        $error("ANG_MAX does not fit in ANG_W bits");
    end
    if (VEL_MAX >= (1 << VEL_W)) begin : g_bad_vel_max
        $error("VEL_MAX does not fit in VEL_W bits");
    end
    if (ORIGIN_Y - AY_ANG * ANG_MAX - AY_VEL * VEL_MAX < 0) begin : g_bad_origin_y
        $error("extreme arrow Y falls below 0");
    end
    if (REPEAT_DLY < 1 || REPEAT_PER < 1 || REPEAT_PER > REPEAT_DLY) begin : g_bad_repeat
        $error("REPEAT_DLY/REPEAT_PER out of range");
    end

    localparam logic [ANG_W-1:0] ANG_TOP = ANG_W'(ANG_MAX);
    localparam logic [VEL_W-1:0] VEL_TOP = VEL_W'(VEL_MAX);

    launch_state_e    r_state;
    launch_state_e    w_state_nxt;
    logic [ANG_W-1:0] r_ang;
    logic [ANG_W-1:0] w_ang_nxt;
    logic [VEL_W-1:0] r_vel;
    logic [VEL_W-1:0] w_vel_nxt;
    logic [1:0]       r_btn;
    logic [1:0]       w_btn_nxt;
    logic             r_launch;
    logic             w_launch_nxt;
    logic             r_fire_prev;
    logic [3:0]       w_pressed;
    logic [3:0]       w_legal;
    logic             w_fire_fall;
    logic             w_sel_valid;
    logic [1:0]       w_sel_idx;
    logic             w_do_step;
    logic [1:0]       w_step_idx;
    logic [10:0]      w_arrow_x;
    logic [10:0]      w_arrow_y;

`ifdef LAUNCH_AUTOREPEAT_EN
    // The counter reloads to DLY-PER after each repeat, so the first repeat
    // lands DLY ticks after the press and later ones every PER ticks.
    localparam int              RPT_W      = $clog2(REPEAT_DLY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DLY - REPEAT_PER);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic [RPT_W-1:0] w_rpt_cnt_nxt;
`endif

    // Legality per button and priority pick: BTN_* index order is the
    // priority order, so scanning downward leaves the lowest legal index.
    always_comb begin
        w_pressed   = ~btn_n;
        w_fire_fall = r_fire_prev & ~fire_n;
        w_legal     = '0;
        w_legal[BTN_ANGUP] = (r_ang < ANG_TOP);
        w_legal[BTN_ANGDN] = (r_ang != '0);
        w_legal[BTN_PWRUP] = (r_vel < VEL_TOP);
        w_legal[BTN_PWRDN] = (r_vel != '0);
        w_sel_valid = 1'b0;
        w_sel_idx   = BTN_ANGUP;
        for (int i = 3; i >= 0; i--) begin
            if (w_pressed[i] && w_legal[i]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_btn_nxt    = r_btn;
        w_launch_nxt = 1'b0;
        w_do_step    = 1'b0;
        w_step_idx   = r_btn;
`ifdef LAUNCH_AUTOREPEAT_EN
        w_rpt_cnt_nxt = r_rpt_cnt;
`endif
        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (lock) begin
                        w_state_nxt = LOCKED;
                    end else if (w_fire_fall) begin
                        w_launch_nxt = 1'b1;
                        w_state_nxt  = LOCKED;
                    end else if (w_sel_valid) begin
                        w_do_step   = 1'b1;
                        w_step_idx  = w_sel_idx;
                        w_btn_nxt   = w_sel_idx;
                        w_state_nxt = HOLD;
`ifdef LAUNCH_AUTOREPEAT_EN
                        w_rpt_cnt_nxt = '0;
`endif
                    end
                end
                HOLD: begin
                    if (w_fire_fall) begin
                        w_launch_nxt = 1'b1;
                        w_state_nxt  = LOCKED;
                    end else if (!w_pressed[r_btn]) begin
                        w_state_nxt = IDLE;
                    end
`ifdef LAUNCH_AUTOREPEAT_EN
                    // An illegal repeat step is dropped by the step logic,
                    // so the value parks at its bound while still held.
                    else if (r_rpt_cnt == RPT_LAST) begin
                        w_do_step     = 1'b1;
                        w_rpt_cnt_nxt = RPT_RELOAD;
                    end else begin
                        w_rpt_cnt_nxt = r_rpt_cnt + 1'b1;
                    end
`endif
                end
                LOCKED: begin
                    if (!lock && (&btn_n) && fire_n) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_ang_nxt = r_ang;
        w_vel_nxt = r_vel;
        if (w_do_step && w_legal[w_step_idx]) begin
            case (w_step_idx)
                BTN_ANGUP: w_ang_nxt = r_ang + 1'b1;
                BTN_ANGDN: w_ang_nxt = r_ang - 1'b1;
                BTN_PWRUP: w_vel_nxt = r_vel + 1'b1;
                BTN_PWRDN: w_vel_nxt = r_vel - 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ang       <= '0;
            r_vel       <= '0;
            r_btn       <= BTN_ANGUP;
            r_launch    <= 1'b0;
            r_fire_prev <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_ang    <= w_ang_nxt;
            r_vel    <= w_vel_nxt;
            r_btn    <= w_btn_nxt;
            r_launch <= w_launch_nxt;
            if (tick) begin
                r_fire_prev <= fire_n;
            end
        end
    end

`ifdef LAUNCH_AUTOREPEAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rpt_cnt <= '0;
        end else begin
            r_rpt_cnt <= w_rpt_cnt_nxt;
        end
    end
`endif

    assign w_arrow_x = 11'(ORIGIN_X) - 11'(r_ang) * 11'(AX_ANG) + 11'(r_vel) * 11'(AX_VEL);
    assign w_arrow_y = 11'(ORIGIN_Y) - 11'(r_ang) * 11'(AY_ANG) - 11'(r_vel) * 11'(AY_VEL);

    arrow_hit #(
        .SZ (ARROW_SZ)
    ) u_arrow_hit (
        .clk       (clk),
        .rst       (rst),
        .i_arrow_x (w_arrow_x),
        .i_arrow_y (w_arrow_y),
        .i_x       (xCount),
        .i_y       (yCount),
        .o_hit     (arrow)
    );

    assign Ang    = r_ang;
    assign Vel    = r_vel;
    assign launch = r_launch;

endmodule

// File: tb/tb_launch_param_ctrl.sv
// tb/tb_launch_param_ctrl.sv - self-checking bench for launch_param_ctrl
module tb_launch_param_ctrl;

    localparam int ANG_W      = 5;
    localparam int ANG_MAX    = 16;
    localparam int VEL_W      = 3;
    localparam int VEL_MAX    = 5;
    localparam int ORIGIN_X   = 31;
    localparam int ORIGIN_Y   = 443;
    localparam int ARROW_SZ   = 10;
    localparam int REPEAT_DLY = 8;
    localparam int REPEAT_PER = 2;

    localparam logic [3:0] B_NONE  = 4'b1111;
    localparam logic [3:0] B_AUP   = 4'b1110;
    localparam logic [3:0] B_ADN   = 4'b1101;
    localparam logic [3:0] B_PUP   = 4'b1011;
    localparam logic [3:0] B_PDN   = 4'b0111;

    localparam int M_IDLE = 0;
    localparam int M_HOLD = 1;
    localparam int M_LOCK = 2;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             tick   = 1'b0;
    logic [3:0]       btn_n  = 4'hF;
    logic             fire_n = 1'b1;
    logic             lock   = 1'b0;
    logic [9:0]       xCount = '0;
    logic [9:0]       yCount = '0;
    logic             arrow;
    logic [ANG_W-1:0] Ang;
    logic [VEL_W-1:0] Vel;
    logic             launch;

    int n_checks = 0;
    int n_fail   = 0;

    int m_ang, m_vel, m_mode, m_btn, m_held;
    bit m_fire_prev;
    bit last_launch;

    launch_param_ctrl #(
        .ANG_W      (ANG_W),
        .ANG_MAX    (ANG_MAX),
        .VEL_W      (VEL_W),
        .VEL_MAX    (VEL_MAX),
        .ORIGIN_X   (ORIGIN_X),
        .ORIGIN_Y   (ORIGIN_Y),
        .ARROW_SZ   (ARROW_SZ),
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .btn_n  (btn_n),
        .fire_n (fire_n),
        .lock   (lock),
        .xCount (xCount),
        .yCount (yCount),
        .arrow  (arrow),
        .Ang    (Ang),
        .Vel    (Vel),
        .launch (launch)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: buttons index 0..3 = angleup, angledown, powerup, powerdown
    function automatic bit m_legal(input int b);
        case (b)
            0:       return m_ang < ANG_MAX;
            1:       return m_ang > 0;
            2:       return m_vel < VEL_MAX;
            default: return m_vel > 0;
        endcase
    endfunction

    task automatic m_apply(input int b);
        if (m_legal(b)) begin
            case (b)
                0:       m_ang++;
                1:       m_ang--;
                2:       m_vel++;
                default: m_vel--;
            endcase
        end
    endtask

    task automatic m_reset();
        m_ang = 0; m_vel = 0; m_mode = M_IDLE; m_btn = 0; m_held = 0;
        m_fire_prev = 1'b1;
    endtask

    task automatic model_tick(input logic [3:0] bn, input logic fn, input logic lk,
                              output bit exp_launch);
        bit fall;
        fall        = m_fire_prev && !fn;
        m_fire_prev = fn;
        exp_launch  = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (lk) begin
                    m_mode = M_LOCK;
                end else if (fall) begin
                    exp_launch = 1'b1;
                    m_mode     = M_LOCK;
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (!bn[b] && m_legal(b)) begin
                            m_apply(b);
                            m_btn  = b;
                            m_held = 0;
                            m_mode = M_HOLD;
                            break;
                        end
                    end
                end
            end
            M_HOLD: begin
                if (fall) begin
                    exp_launch = 1'b1;
                    m_mode     = M_LOCK;
                end else if (bn[m_btn]) begin
                    m_mode = M_IDLE;
                end else begin
                    m_held++;
`ifdef LAUNCH_AUTOREPEAT_EN
                    if (m_held >= REPEAT_DLY && ((m_held - REPEAT_DLY) % REPEAT_PER) == 0)
                        m_apply(m_btn);
`endif
                end
            end
            default: begin
                if (!lk && bn == 4'hF && fn) m_mode = M_IDLE;
            end
        endcase
    endtask

    // One tick with given inputs, then 1..3 non-tick clocks with junk inputs
    task automatic do_tick(input logic [3:0] b, input logic f, input logic l);
        bit el;
        int gap;
        btn_n = b; fire_n = f; lock = l; tick = 1'b1;
        model_tick(b, f, l, el);
        @(negedge clk);
        tick = 1'b0;
        last_launch = launch;
        chk_eq("ang", 32'(Ang), 32'(m_ang));
        chk_eq("vel", 32'(Vel), 32'(m_vel));
        chk_eq("launch", 32'(launch), 32'(el));
        gap = $urandom_range(1, 3);
        for (int i = 0; i < gap; i++) begin
            btn_n  = 4'($urandom);
            fire_n = 1'($urandom);
            lock   = 1'($urandom);
            @(negedge clk);
            chk_eq("launch_gap", 32'(launch), 32'd0);
            chk_eq("ang_gap", 32'(Ang), 32'(m_ang));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; tick = 1'b0; btn_n = 4'hF; fire_n = 1'b1; lock = 1'b0;
        xCount = 10'd35; yCount = 10'd447;
        repeat (2) @(negedge clk);
        chk_eq("rst_ang", 32'(Ang), 32'd0);
        chk_eq("rst_vel", 32'(Vel), 32'd0);
        chk_eq("rst_launch", 32'(launch), 32'd0);
        chk_eq("rst_arrow", 32'(arrow), 32'd0);
        m_reset();
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_pixel(input int x, input int y);
        int ax, ay;
        bit e;
        xCount = 10'(x); yCount = 10'(y);
        @(negedge clk);
        ax = (ORIGIN_X - m_ang + 4 * m_vel) & 2047;
        ay = (ORIGIN_Y - 4 * m_ang - 10 * m_vel) & 2047;
        e  = (ax < x) && (x < ((ax + ARROW_SZ) & 2047)) &&
             (ay < y) && (y < ((ay + ARROW_SZ) & 2047));
        chk_eq("arrow", 32'(arrow), 32'(e));
    endtask

    task automatic rand_pixel();
        int ax, ay;
        ax = (ORIGIN_X - m_ang + 4 * m_vel) & 2047;
        ay = (ORIGIN_Y - 4 * m_ang - 10 * m_vel) & 2047;
        chk_pixel(ax - 1 + int'($urandom_range(0, 12)), ay - 1 + int'($urandom_range(0, 12)));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cur_b;
        m_reset();

        // Reset release and arrow at the origin
        do_reset();
        xCount = 10'd35; yCount = 10'd447;
        @(negedge clk);
        chk_eq("pix_35_447", 32'(arrow), 32'd1);
        xCount = 10'd31; yCount = 10'd443;
        @(negedge clk);
        chk_eq("pix_31_443", 32'(arrow), 32'd0);

        // angleup held: single step, or auto-repeat to saturation
        do_reset();
        for (int t = 0; t < 20; t++) do_tick(B_AUP, 1'b1, 1'b0);
`ifdef LAUNCH_AUTOREPEAT_EN
        chk_eq("hold20_ang", 32'(Ang), 32'd7);
`else
        chk_eq("hold20_ang", 32'(Ang), 32'd1);
`endif
        for (int t = 0; t < 30; t++) do_tick(B_AUP, 1'b1, 1'b0);
`ifdef LAUNCH_AUTOREPEAT_EN
        chk_eq("hold50_ang", 32'(Ang), 32'd16);
`else
        chk_eq("hold50_ang", 32'(Ang), 32'd1);
`endif
        rand_pixel();
        do_tick(B_NONE, 1'b1, 1'b0);

        // angleup + powerup together, then powerup alone
        do_reset();
        do_tick(B_AUP & B_PUP, 1'b1, 1'b0);
        chk_eq("both_ang", 32'(Ang), 32'd1);
        chk_eq("both_vel", 32'(Vel), 32'd0);
        do_tick(B_PUP, 1'b1, 1'b0);
        do_tick(B_PUP, 1'b1, 1'b0);
        chk_eq("pup_vel", 32'(Vel), 32'd1);

        // powerdown at Vel=0 is illegal and leaves the FSM idle
        do_reset();
        do_tick(B_PDN, 1'b1, 1'b0);
        chk_eq("pdn0_vel", 32'(Vel), 32'd0);
        do_tick(B_PDN & B_AUP, 1'b1, 1'b0);
        chk_eq("pdn0_idle", 32'(Ang), 32'd1);
        do_tick(B_NONE, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_tick(B_PUP, 1'b1, 1'b0);
            do_tick(B_NONE, 1'b1, 1'b0);
        end
        chk_eq("vel3", 32'(Vel), 32'd3);
        do_tick(B_PDN, 1'b1, 1'b0);
        chk_eq("pdn3_vel", 32'(Vel), 32'd2);
        rand_pixel();

        // fire with angledown: one launch, Ang kept, locked until release
        do_reset();
        for (int i = 0; i < 2; i++) begin
            do_tick(B_AUP, 1'b1, 1'b0);
            do_tick(B_NONE, 1'b1, 1'b0);
        end
        do_tick(B_ADN, 1'b0, 1'b0);
        chk_eq("fire_pulse", 32'(last_launch), 32'd1);
        chk_eq("fire_ang", 32'(Ang), 32'd2);
        do_tick(B_ADN, 1'b0, 1'b1);
        do_tick(B_AUP, 1'b1, 1'b0);
        do_tick(B_NONE, 1'b0, 1'b0);
        chk_eq("locked_ang", 32'(Ang), 32'd2);
        do_tick(B_NONE, 1'b1, 1'b0);
        do_tick(B_AUP, 1'b1, 1'b0);
        chk_eq("unlock_ang", 32'(Ang), 32'd3);

        // Asynchronous reset in the middle of a held press
        do_reset();
        for (int t = 0; t < 12; t++) do_tick(B_AUP, 1'b1, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("arst_ang", 32'(Ang), 32'd0);
        chk_eq("arst_launch", 32'(launch), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk_eq("arst_hold_launch", 32'(launch), 32'd0);
            chk_eq("arst_hold_ang", 32'(Ang), 32'd0);
        end
        m_reset();
        btn_n = 4'hF; fire_n = 1'b1; lock = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        // Randomized run against the model
        cur_b = B_NONE;
        for (int n = 0; n < 200; n++) begin
            logic f, l;
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 6))
                    0, 1: cur_b = B_NONE;
                    2:    cur_b = B_AUP;
                    3:    cur_b = B_ADN;
                    4:    cur_b = B_PUP;
                    5:    cur_b = B_PDN;
                    default: cur_b = 4'($urandom);
                endcase
            end
            f = ($urandom_range(0, 9) != 0);
            l = ($urandom_range(0, 7) == 0);
            do_tick(cur_b, f, l);
            if ((n % 4) == 0) rand_pixel();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
